bcd_display_driver: RTL and testbench

Sequential binary-to-decimal display driver for the multi-digit seven-segment bank. It accepts an unsigned binary value on a load strobe and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It then registers NUM_DIGITS active-low segment patterns, with optional leading-zero blanking and overflow indication. It sits between the reaction-time counter and the board HEX pins, and replaces per-digit combinational decoding plus external division.

---
 rtl/bcd_display_driver.sv | 118 +++++++++++
 tb/tb_bcd_display_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_driver.sv
// bcd_display_driver: serial double-dabble binary-to-BCD converter feeding a registered,
// active-low seven-segment bank with leading-zero blanking and overflow dashes.
module bcd_display_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_WIDTH     = 14,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    load,
    input  logic                    blank_all,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    // 64-bit limit so 10^8 and a 32-bit value compare without truncation
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0011000;
            default: seg = BLANK;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

    state_t                  state, state_nx;
    logic [BIN_WIDTH-1:0]    sh;
    logic [BW-1:0]           bcd, adj;
    logic [CW-1:0]           cnt;
    logic [7*NUM_DIGITS-1:0] disp, disp_nx;
    logic                    lead;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = load ? SHIFT : IDLE;
            SHIFT:   state_nx = (cnt == CW'(BIN_WIDTH - 1)) ? UPDATE : SHIFT;
            UPDATE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        adj = bcd;
        for (int k = 0; k < NUM_DIGITS; k++)
            adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    // walk from the most significant digit so lead tracks "all zero so far"
    always_comb begin
        lead    = 1'b1;
        disp_nx = '1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead = lead && (bcd[4*k +: 4] == 4'd0);
            disp_nx[7*k +: 7] = overflow ? DASH :
                                (BLANK_LEADING != 0 && lead && k > 0) ? BLANK : seg(bcd[4*k +: 4]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            disp     <= '1;
            done     <= 1'b0;
        end else begin
            done <= (state == UPDATE);
            if (state == IDLE && load) begin
                sh       <= value;
                bcd      <= '0;
                cnt      <= '0;
                overflow <= 64'(value) >= LIMIT;
            end
            if (state == SHIFT) begin
                bcd <= {adj[BW-2:0], sh[BIN_WIDTH-1]};
                sh  <= sh << 1;
                cnt <= cnt + 1'b1;
            end
            if (state == UPDATE) disp <= disp_nx;
        end
    end

    assign busy    = (state != IDLE);
    assign hex_out = blank_all ? '1 : disp;

endmodule

// File: tb/tb_bcd_display_driver.sv
// tb_bcd_display_driver: vector table plus scoreboard of expected displays, popped on each done pulse.
module tb_bcd_display_driver;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000, S9 = 7'b0011000;
    localparam logic [6:0] BL = 7'b1111111, DA = 7'b0111111;

    typedef struct {
        logic [13:0] v;
        logic [27:0] hex;
        logic [27:0] hex0;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, load = 1'b0, blank_all = 1'b0;
    logic [13:0] value = '0;
    logic [27:0] hex_out, hex_out0;
    logic        busy, done, overflow, busy0, done0, overflow0;
    int          tests = 0, fails = 0;
    vec_t        sbq[$];
    vec_t        vecs[8];

    always #5 clk = ~clk;

    bcd_display_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank_all(blank_all),
        .hex_out(hex_out), .busy(busy), .done(done), .overflow(overflow));

    bcd_display_driver #(.NUM_DIGITS(4), .BIN_WIDTH(14), .BLANK_LEADING(0)) dut0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .blank_all(blank_all),
        .hex_out(hex_out0), .busy(busy0), .done(done0), .overflow(overflow0));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
            end else begin
                vec_t e;
                e = sbq.pop_front();
                chk("hex_blank", 32'(hex_out), 32'(e.hex));
                chk("hex_noblank", 32'(hex_out0), 32'(e.hex0));
                chk("ovf_result", 32'(overflow), 32'(e.ovf));
                chk("done_both", 32'(done0), 32'd1);
            end
        end
    end

    task automatic run_load(input vec_t t);
        int n;
        @(negedge clk);
        value = t.v;
        load  = 1'b1;
        sbq.push_back(t);
        @(negedge clk);
        load = 1'b0;
        chk("ovf_at_accept", 32'(overflow), 32'(t.ovf));
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", n, 15);
        chk("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        vec_t t;
        vecs[0] = '{14'd1234,  {S1, S2, S3, S4}, {S1, S2, S3, S4}, 1'b0};
        vecs[1] = '{14'd7,     {BL, BL, BL, S7}, {S0, S0, S0, S7}, 1'b0};
        vecs[2] = '{14'd0,     {BL, BL, BL, S0}, {S0, S0, S0, S0}, 1'b0};
        vecs[3] = '{14'd10000, {DA, DA, DA, DA}, {DA, DA, DA, DA}, 1'b1};
        vecs[4] = '{14'd9999,  {S9, S9, S9, S9}, {S9, S9, S9, S9}, 1'b0};
        vecs[5] = '{14'd50,    {BL, BL, S5, S0}, {S0, S0, S5, S0}, 1'b0};
        vecs[6] = '{14'd1005,  {S1, S0, S0, S5}, {S1, S0, S0, S5}, 1'b0};
        vecs[7] = '{14'd16383, {DA, DA, DA, DA}, {DA, DA, DA, DA}, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_hex", 32'(hex_out), 32'hFFFFFFF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_load(vecs[i]);
            repeat (2) @(negedge clk);
            chk("ovf_hold", 32'(overflow), 32'(vecs[i].ovf));
            chk("hex_hold", 32'(hex_out), 32'(vecs[i].hex));
        end

        // load while busy is dropped; load during the done cycle is taken
        @(negedge clk);
        value = 14'd42;
        load  = 1'b1;
        sbq.push_back('{14'd42, {BL, BL, S4, S2}, {S0, S0, S4, S2}, 1'b0});
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        value = 14'd99;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = '0;
        n = 0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("done_42", 32'(done), 32'd1);
        chk("hex_42", 32'(hex_out), {4'h0, BL, BL, S4, S2});
        value = 14'd5;
        load  = 1'b1;
        sbq.push_back('{14'd5, {BL, BL, BL, S5}, {S0, S0, S0, S5}, 1'b0});
        @(negedge clk);
        load = 1'b0;
        chk("accept_in_done", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("done_5", 32'(done), 32'd1);
        repeat (20) @(negedge clk);
        chk("sbq_empty", sbq.size(), 0);

        // asynchronous reset mid-conversion aborts without a done
        value = 14'd1234;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hex", 32'(hex_out), 32'hFFFFFFF);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("abort_no_done", n, 0);
        t = '{14'd5, {BL, BL, BL, S5}, {S0, S0, S0, S5}, 1'b0};
        run_load(t);

        // blank_all masks the display combinationally
        run_load(vecs[0]);
        @(negedge clk);
        blank_all = 1'b1;
        #1;
        chk("blank_all_on", 32'(hex_out), 32'hFFFFFFF);
        chk("blank_all_busy", 32'(busy), 32'd0);
        @(negedge clk);
        blank_all = 1'b0;
        #1;
        chk("blank_all_off", 32'(hex_out), {4'h0, S1, S2, S3, S4});
        chk("blank_all_nodone", 32'(done), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
